// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: state encoding and default operand widths shared by the divider files
package seq_divider_pkg;
    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, trial-subtract, keep if non-negative)
//   part_rem : partial remainder entering the iteration (DIVISOR_W+1 bits)
//   next_bit : next dividend bit, MSB first
//   divisor  : unsigned divisor
//   new_rem  : partial remainder after the iteration
//   q_bit    : quotient bit produced by the iteration
module div_step
    import seq_divider_pkg::*;
#(
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W:0]   part_rem,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   new_rem,
    output logic                 q_bit
);
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] trial;
    // The shifted value is below 2*divisor, so the top bit of the
    // difference is a reliable borrow/sign flag.
    always_comb begin
        shifted = {part_rem, next_bit};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[DIVISOR_W+1];
        new_rem = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   start        : request a division, sampled only while idle
//   dividend     : unsigned dividend, captured on the start edge
//   divisor      : unsigned divisor, captured on the start edge
//   quotient     : registered quotient, updated only on entry to DONE
//   remainder    : registered remainder, updated only on entry to DONE
//   busy         : high while a division is running or completing
//   done         : one-cycle pulse marking valid results
//   div_by_zero  : the last captured divisor was zero
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    // Holds the unconsumed dividend bits at the top and the quotient bits
    // shifted in at the bottom; after the last iteration it is the quotient.
    logic [DIVIDEND_W-1:0] shreg;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W:0]    prem;
    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q;
    logic                  last;

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .part_rem (prem),
        .next_bit (shreg[DIVIDEND_W-1]),
        .divisor  (dvs),
        .new_rem  (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        last      = cnt == LAST;
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? (divisor == '0 ? DONE : RUN) : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
        busy = state == RUN || state == DONE;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            dvs         <= '0;
            prem        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    shreg       <= dividend;
                    dvs         <= divisor;
                    prem        <= '0;
                    cnt         <= '0;
                    div_by_zero <= divisor == '0;
                    if (divisor == '0) begin
                        quotient  <= '1;
                        remainder <= '0;
                    end
                end
                RUN: begin
                    shreg <= {shreg[DIVIDEND_W-2:0], step_q};
                    prem  <= step_rem;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        quotient  <= {shreg[DIVIDEND_W-2:0], step_q};
                        remainder <= step_rem[DIVISOR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed self-checking bench for seq_divider
module tb_seq_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    // Reference: plain integer division; a zero divisor yields all-ones / zero.
    function automatic logic [DW-1:0] ref_q(input int a, input int b);
        return b == 0 ? {DW{1'b1}} : DW'(a / b);
    endfunction
    function automatic logic [VW-1:0] ref_r(input int a, input int b);
        return b == 0 ? '0 : VW'(a % b);
    endfunction
    // Edges after the start edge before Done is visible.
    function automatic int ref_lat(input int b);
        return b == 0 ? 0 : DW;
    endfunction

    // Launches one division, scrambles the operand inputs right after capture,
    // and reports latency, results, pulse shape and result stability.
    task automatic run_div(input int a, input int b, output int lat, output logic [DW-1:0] q,
                           output logic [VW-1:0] r, output logic dbz, output logic pulse_ok,
                           output logic hold_ok);
        logic [DW-1:0] q0;
        logic [VW-1:0] r0;
        int guard = 0;
        while (busy && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        q0 = quotient;
        r0 = remainder;
        hold_ok = 1'b1;
        dividend = DW'(a);
        divisor = VW'(b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = DW'($urandom);
        divisor = VW'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            if (quotient !== q0 || remainder !== r0) hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        dbz = div_by_zero;
        @(posedge clk); #1;
        pulse_ok = !done && !busy;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got q=%0h r=%0h busy=%b done=%b dbz=%b want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        int a_t[3] = '{200, 255, 5};
        int b_t[3] = '{7, 15, 9};
        int lat;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dbz, pok, hok;
        for (int i = 0; i < 3; i++) begin
            run_div(a_t[i], b_t[i], lat, q, r, dbz, pok, hok);
            checks++;
            if (q !== ref_q(a_t[i], b_t[i]) || r !== ref_r(a_t[i], b_t[i])) begin
                errors++;
                $display("FAIL directed_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d",
                         a_t[i], b_t[i], q, r, ref_q(a_t[i], b_t[i]), ref_r(a_t[i], b_t[i]));
            end
            checks++;
            if (lat !== ref_lat(b_t[i]) || dbz !== 1'b0) begin
                errors++;
                $display("FAIL directed_latency %0d/%0d got lat=%0d dbz=%b want lat=%0d dbz=0",
                         a_t[i], b_t[i], lat, dbz, ref_lat(b_t[i]));
            end
            checks++;
            if (pok !== 1'b1 || hok !== 1'b1) begin
                errors++;
                $display("FAIL directed_pulse_hold %0d/%0d got pulse_ok=%b hold_ok=%b want 1 1",
                         a_t[i], b_t[i], pok, hok);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dbz, pok, hok;
        run_div(8'h42, 0, lat, q, r, dbz, pok, hok);
        checks++;
        if (q !== 8'hFF || r !== 4'h0 || dbz !== 1'b1) begin
            errors++;
            $display("FAIL div_zero_result got q=%0h r=%0h dbz=%b want q=ff r=0 dbz=1", q, r, dbz);
        end
        checks++;
        if (lat !== 0 || pok !== 1'b1) begin
            errors++;
            $display("FAIL div_zero_timing got lat=%0d pulse_ok=%b want lat=0 pulse_ok=1", lat, pok);
        end
        run_div(9, 3, lat, q, r, dbz, pok, hok);
        checks++;
        if (dbz !== 1'b0 || q !== 8'd3 || r !== 4'd0) begin
            errors++;
            $display("FAIL div_zero_clear got q=%0d r=%0d dbz=%b want q=3 r=0 dbz=0", q, r, dbz);
        end
    endtask

    task automatic test_start_ignored();
        int n_done = 0;
        int first = -1;
        dividend = 8'd200;
        divisor = 4'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) begin
                dividend = 8'd100;
                divisor = 4'd3;
                start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (first < 0) first = i;
            end
            if (i == 8) begin
                checks++;
                if (quotient !== 8'd28 || remainder !== 4'd4) begin
                    errors++;
                    $display("FAIL ignored_start_result got q=%0d r=%0d want q=28 r=4", quotient, remainder);
                end
            end
        end
        checks++;
        if (n_done !== 1 || first !== DW || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_pulses got n_done=%0d first=%0d busy=%b want 1 %0d 0",
                     n_done, first, busy, DW);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int n_done = 0;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dbz, pok, hok;
        dividend = 8'd200;
        divisor = 4'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got q=%0d r=%0d busy=%b done=%b dbz=%b want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (i == 2) rst_n = 1'b1;
        end
        checks++;
        if (n_done !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandons got n_done=%0d busy=%b want 0 0", n_done, busy);
        end
        run_div(9, 2, lat, q, r, dbz, pok, hok);
        checks++;
        if (q !== 8'd4 || r !== 4'd1 || lat !== DW) begin
            errors++;
            $display("FAIL after_reset_div got q=%0d r=%0d lat=%0d want q=4 r=1 lat=%0d", q, r, lat, DW);
        end
    endtask

    task automatic test_back_to_back();
        int d_idx[$];
        logic [DW-1:0] qs[$];
        logic [VW-1:0] rs[$];
        dividend = 8'd77;
        divisor = 4'd6;
        start = 1'b1;
        @(posedge clk); #1;
        dividend = 8'd131;
        divisor = 4'd11;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                d_idx.push_back(i);
                qs.push_back(quotient);
                rs.push_back(remainder);
            end
            if (i == 12) start = 1'b0;
        end
        checks++;
        if (d_idx.size() !== 2) begin
            errors++;
            $display("FAIL back_to_back_count got %0d done pulses want 2", d_idx.size());
        end else begin
            checks++;
            if (d_idx[0] !== DW || d_idx[1] !== 2 * DW + 2) begin
                errors++;
                $display("FAIL back_to_back_timing got %0d,%0d want %0d,%0d",
                         d_idx[0], d_idx[1], DW, 2 * DW + 2);
            end
            checks++;
            if (qs[0] !== ref_q(77, 6) || rs[0] !== ref_r(77, 6) ||
                qs[1] !== ref_q(131, 11) || rs[1] !== ref_r(131, 11)) begin
                errors++;
                $display("FAIL back_to_back_results got %0d r%0d, %0d r%0d want %0d r%0d, %0d r%0d",
                         qs[0], rs[0], qs[1], rs[1], ref_q(77, 6), ref_r(77, 6),
                         ref_q(131, 11), ref_r(131, 11));
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lat, a, b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dbz, pok, hok;
        for (int i = 0; i < 60; i++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            run_div(a, b, lat, q, r, dbz, pok, hok);
            checks++;
            if (q !== ref_q(a, b) || r !== ref_r(a, b) || dbz !== (b == 0) ||
                lat !== ref_lat(b) || pok !== 1'b1 || hok !== 1'b1) begin
                errors++;
                $display("FAIL random %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d pulse=%b hold=%b want q=%0d r=%0d dbz=%b lat=%0d",
                         a, b, q, r, dbz, lat, pok, hok, ref_q(a, b), ref_r(a, b), b == 0, ref_lat(b));
            end
        end
    endtask

    task automatic test_exhaustive();
        int lat;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dbz, pok, hok;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(a, b, lat, q, r, dbz, pok, hok);
                checks++;
                if (int'(q) * b + int'(r) != a || int'(r) >= b) begin
                    errors++;
                    $display("FAIL exhaustive %0d/%0d got q=%0d r=%0d want q=%0d r=%0d",
                             a, b, q, r, a / b, a % b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
